// File: rtl/id_ex_mem_datapath.sv
// Decode/execute/data-memory slice of a single-cycle MIPS datapath: register file,
// immediate decode, ALU and word-addressed data memory. Optional macro ALU_SLT_EN enables op 111 = signed SLT.
module id_ex_mem_datapath #(
    parameter int DM_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic [31:0] wd,
    input  logic        RegDst,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic [2:0]  op,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic [25:0] jTarget,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] memOut
);

    localparam int DM_DEPTH = 2 ** DM_ADDR_W;

    logic [4:0]  rs, rt, wn;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] alu_b;
    logic [DM_ADDR_W-1:0] dm_idx;
    logic [31:0] dmem [DM_DEPTH];

    assign rs      = ins[25:21];
    assign rt      = ins[20:16];
    assign wn      = RegDst ? ins[15:11] : ins[20:16];
    assign imm     = {{16{ins[15]}}, ins[15:0]};
    assign jTarget = ins[25:0];

    // Register 0 is forced to zero on read so it holds even before the first reset.
    assign rd1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rd2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (wn != 5'd0))
            regs_d[wn] = wd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= 32'd0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign alu_b = ALUSrc ? imm : rd2;

    always_comb begin
        z = 32'd0;
        case (op)
            3'b000: z = rd1 & alu_b;
            3'b001: z = rd1 | alu_b;
            3'b010: z = rd1 + alu_b;
            3'b110: z = rd1 - alu_b;
`ifdef ALU_SLT_EN
            3'b111: z = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
`else
            3'b111: z = 32'd0;
`endif
            default: z = 32'd0;
        endcase
    end

    assign zero = (z == 32'd0);

    // Byte address bits and bits above the memory size are dropped, so addresses alias.
    assign dm_idx = z[DM_ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst_n && MemWrite)
            dmem[dm_idx] <= rd2;
    end

    assign memOut = MemRead ? dmem[dm_idx] : 32'd0;

endmodule

// File: tb/tb_id_ex_mem_datapath.sv
// Scoreboard bench for id_ex_mem_datapath: directed plan followed by random traffic,
// expected outputs from a behavioural model pushed to a queue and checked by a monitor.
module tb_id_ex_mem_datapath;

    localparam int DM_ADDR_W = 10;
    localparam int DEPTH     = 2 ** DM_ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins, wd;
    logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, z, memOut;
    logic [25:0] jTarget;
    logic        zero;

    id_ex_mem_datapath #(.DM_ADDR_W(DM_ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .wd(wd), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead),
        .MemWrite(MemWrite), .rd1(rd1), .rd2(rd2), .imm(imm), .jTarget(jTarget),
        .z(z), .zero(zero), .memOut(memOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1, rd2, imm, z, mo;
        logic [25:0] jt;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0;

    // Reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [int];

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] n);
        return (n == 0) ? 32'd0 : m_regs[n];
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd6: return a - b;
`ifdef ALU_SLT_EN
            3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_idx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Commit the edge that just happened using the inputs that were held across it.
    task automatic model_edge();
        logic [31:0] a_now;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            a_now = m_alu(op, m_read(ins[25:21]), ALUSrc ? sx(ins[15:0]) : m_read(ins[20:16]));
            if (MemWrite) m_mem[m_idx(a_now)] = m_read(ins[20:16]);
            if (RegWrite) begin
                if (RegDst) begin
                    if (ins[15:11] != 0) m_regs[ins[15:11]] = wd;
                end else if (ins[20:16] != 0) m_regs[ins[20:16]] = wd;
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic [31:0] w,
                        input logic rdst, input logic rw, input logic asrc,
                        input logic [2:0] o, input logic mr, input logic mw);
        exp_t e;
        logic [31:0] a, b;
        @(posedge clk);
        #1;
        model_edge();
        rst_n = r; ins = i; wd = w; RegDst = rdst; RegWrite = rw;
        ALUSrc = asrc; op = o; MemWrite = mw;
        a = m_read(i[25:21]);
        b = asrc ? sx(i[15:0]) : m_read(i[20:16]);
        e.rd1  = a;
        e.rd2  = m_read(i[20:16]);
        e.imm  = sx(i[15:0]);
        e.jt   = i[25:0];
        e.z    = m_alu(o, a, b);
        e.zero = (e.z == 0);
        // Never read a word the model has not seen written.
        MemRead = mr && m_mem.exists(m_idx(e.z));
        e.mo   = MemRead ? m_mem[m_idx(e.z)] : 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd1", rd1, e.rd1);
            chk("rd2", rd2, e.rd2);
            chk("imm", imm, e.imm);
            chk("jTarget", {6'd0, jTarget}, {6'd0, e.jt});
            chk("z", z, e.z);
            chk("zero", {31'd0, zero}, {31'd0, e.zero});
            chk("memOut", memOut, e.mo);
        end
    end

    initial begin
        int wait_cyc;
        logic [4:0] r_s, r_t, r_d;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst_n = 0; ins = 0; wd = 0; RegDst = 0; RegWrite = 0; ALUSrc = 0;
        op = 0; MemRead = 0; MemWrite = 0;

        // reset, then reg1=5, reg2=7
        step(0, 32'h00221820, 0, 0, 1, 0, 3'd2, 0, 0);
        step(1, 32'h00221820, 0, 0, 0, 0, 3'd2, 0, 0);
        step(1, {6'd0, 5'd0, 5'd1, 16'd0}, 5, 0, 1, 0, 3'd2, 0, 0);
        step(1, {6'd0, 5'd0, 5'd2, 16'd0}, 7, 0, 1, 0, 3'd2, 0, 0);
        // add $3,$1,$2 with write-back of 12
        step(1, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 12, 1, 1, 0, 3'd2, 0, 0);
        step(1, {6'd0, 5'd3, 5'd3, 5'd0, 5'd0, 6'h20}, 0, 0, 0, 0, 3'd2, 0, 0);
        // addi/ori with imm FFFF
        step(1, {6'h08, 5'd1, 5'd4, 16'hFFFF}, 0, 0, 0, 1, 3'd2, 0, 0);
        step(1, {6'h08, 5'd1, 5'd4, 16'hFFFF}, 0, 0, 0, 1, 3'd1, 0, 0);
        // beq compares
        step(1, {6'h04, 5'd1, 5'd1, 16'd0}, 0, 0, 0, 0, 3'd6, 0, 0);
        step(1, {6'h04, 5'd1, 5'd2, 16'd0}, 0, 0, 0, 0, 3'd6, 0, 0);
        // sw/lw, disabled read, aliased address
        step(1, {6'h2b, 5'd1, 5'd2, 16'd8}, 0, 0, 0, 1, 3'd2, 0, 1);
        step(1, {6'h23, 5'd1, 5'd2, 16'd8}, 0, 0, 0, 1, 3'd2, 1, 0);
        step(1, {6'h23, 5'd1, 5'd2, 16'd8}, 0, 0, 0, 1, 3'd2, 0, 0);
        step(1, {6'h23, 5'd1, 5'd2, 16'd4104}, 0, 0, 0, 1, 3'd2, 1, 0);
        // read-during-write of the same word
        step(1, {6'h2b, 5'd1, 5'd3, 16'd8}, 0, 0, 0, 1, 3'd2, 1, 1);
        step(1, {6'h23, 5'd1, 5'd3, 16'd8}, 0, 0, 0, 1, 3'd2, 1, 0);
        // $0 write discarded; reg5 = -1 for SLT
        step(1, {6'd0, 5'd0, 5'd0, 16'd0}, 99, 0, 1, 0, 3'd2, 0, 0);
        step(1, {6'd0, 5'd0, 5'd5, 16'd0}, 32'hFFFFFFFF, 0, 1, 0, 3'd2, 0, 0);
        step(1, {6'd0, 5'd1, 5'd0, 16'hFFFF}, 0, 0, 0, 1, 3'd7, 0, 0);
        step(1, {6'd0, 5'd5, 5'd0, 16'd5}, 0, 0, 0, 1, 3'd7, 0, 0);
        // reset wins over RegWrite
        step(0, {6'd0, 5'd1, 5'd6, 16'd0}, 42, 0, 1, 0, 3'd2, 0, 1);
        step(1, {6'd0, 5'd1, 5'd6, 16'd0}, 0, 0, 0, 0, 3'd2, 0, 0);

        for (int n = 0; n < 500; n++) begin
            r_s = 5'($urandom_range(0, 7));
            r_t = 5'($urandom_range(0, 7));
            r_d = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 49) != 0),
                 {6'($urandom), r_s, r_t, r_d, 11'($urandom)},
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
